// File: rtl/dbus_pkg.sv
// Shared constants, state encoding and width helpers for the data-bus master.
package dbus_pkg;

    // Bus source indices
    localparam int unsigned SRC_DR  = 0;
    localparam int unsigned SRC_R0  = 1;
    localparam int unsigned SRC_R1  = 2;
    localparam int unsigned SRC_R2  = 3;
    localparam int unsigned SRC_R3  = 4;
    localparam int unsigned SRC_ALU = 5;

    // Destination load-strobe bit positions
    localparam int unsigned DST_A  = 0;
    localparam int unsigned DST_B  = 1;
    localparam int unsigned DST_IR = 2;
    localparam int unsigned DST_PC = 3;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Bits needed to index n sources (at least one)
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Setup counter must hold values 0..setup_cyc
    function automatic int unsigned cnt_width(input int unsigned setup_cyc);
        return (setup_cyc < 1) ? 1 : $clog2(setup_cyc + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter
    import dbus_pkg::*;
#(
    parameter int unsigned NSRC = 6,
    localparam int unsigned IDX_W = idx_width(NSRC)
) (
    input  logic [NSRC-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid_c,
    output logic [IDX_W-1:0] idx_c
);

    int unsigned          k;
    logic [IDX_W-1:0]     kk;

    // Scan upward from ptr and keep the first hit
    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        k       = 0;
        kk      = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            k = 32'(ptr) + i;
            if (k >= NSRC) begin
                k = k - NSRC;
            end
            kk = IDX_W'(k);
            if (!valid_c && req[kk]) begin
                valid_c = 1'b1;
                idx_c   = kk;
            end
        end
    end

endmodule

// File: rtl/dbus_master.sv
// Transmit-side data-bus master: round-robin grant, drive, load strobe, turnaround.
module dbus_master
    import dbus_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NSRC      = 6,
    parameter int unsigned NDST      = 4,
    parameter int unsigned SETUP_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NSRC-1:0]       req,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC*NDST-1:0]  src_dst,
    output logic [NSRC-1:0]       drv_en,
    output logic                  bus_oe,
    output logic [WIDTH-1:0]      bus_data,
    output logic [NDST-1:0]       ld,
    output logic [NSRC-1:0]       gnt,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned IDX_W = idx_width(NSRC);
    localparam int unsigned CNT_W = cnt_width(SETUP_CYC);

    state_t           state, state_n;
    logic [IDX_W-1:0] sel, sel_n;
    logic [WIDTH-1:0] dat, dat_n;
    logic [NDST-1:0]  msk, msk_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_n;

    logic [NSRC-1:0]  drv_en_n;
    logic             bus_oe_n;
    logic [WIDTH-1:0] bus_data_n;
    logic [NDST-1:0]  ld_n;
    logic [NSRC-1:0]  gnt_n;
    logic             busy_n;
    logic             err_n;

    logic             arb_valid;
    logic [IDX_W-1:0] arb_idx;

    rr_arbiter #(
        .NSRC (NSRC)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .valid_c (arb_valid),
        .idx_c   (arb_idx)
    );

    // Next-state sequencing plus the output values for the state being entered
    always_comb begin
        state_n    = state;
        sel_n      = sel;
        dat_n      = dat;
        msk_n      = msk;
        cnt_n      = cnt;
        rr_ptr_n   = rr_ptr;
        drv_en_n   = '0;
        bus_oe_n   = 1'b0;
        bus_data_n = '0;
        ld_n       = '0;
        gnt_n      = '0;
        busy_n     = 1'b0;
        err_n      = 1'b0;

        case (state)
            IDLE: begin
                if (arb_valid) begin
                    sel_n   = arb_idx;
                    dat_n   = src_data[32'(arb_idx)*WIDTH +: WIDTH];
                    msk_n   = src_dst[32'(arb_idx)*NDST +: NDST];
                    cnt_n   = '0;
                    state_n = DRIVE;
                end
            end
            DRIVE: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(SETUP_CYC - 1)) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                state_n  = IDLE;
                rr_ptr_n = (32'(sel) == NSRC - 1) ? '0 : sel + IDX_W'(1);
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are registered, so they follow the state we are moving into
        if (state_n != IDLE) begin
            drv_en_n   = NSRC'(1) << sel_n;
            bus_oe_n   = 1'b1;
            bus_data_n = dat_n;
            busy_n     = 1'b1;
        end
        if (state_n == LOAD) begin
            ld_n  = msk_n;
            gnt_n = NSRC'(1) << sel_n;
            err_n = (msk_n == '0);
        end
    end

    // State, latched transfer and registered outputs; reset aborts any transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            dat      <= '0;
            msk      <= '0;
            cnt      <= '0;
            rr_ptr   <= '0;
            drv_en   <= '0;
            bus_oe   <= 1'b0;
            bus_data <= '0;
            ld       <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            dat      <= dat_n;
            msk      <= msk_n;
            cnt      <= cnt_n;
            rr_ptr   <= rr_ptr_n;
            drv_en   <= drv_en_n;
            bus_oe   <= bus_oe_n;
            bus_data <= bus_data_n;
            ld       <= ld_n;
            gnt      <= gnt_n;
            busy     <= busy_n;
            err      <= err_n;
        end
    end

endmodule

// File: tb/tb_dbus_master.sv
// Bench for dbus_master: transfer-level reference model plus directed and random traffic.
module tb_dbus_master;

    localparam int W  = 8;
    localparam int N  = 6;
    localparam int D  = 4;
    localparam int S  = 1;
    localparam int S3 = 3;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] src_data;
    logic [N*D-1:0] src_dst;
    logic [N-1:0]   drv_en;
    logic           bus_oe;
    logic [W-1:0]   bus_data;
    logic [D-1:0]   ld;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           err;

    logic [N-1:0]   req3;
    logic [N*W-1:0] src_data3;
    logic [N*D-1:0] src_dst3;
    logic [N-1:0]   drv_en3;
    logic           bus_oe3;
    logic [W-1:0]   bus_data3;
    logic [D-1:0]   ld3;
    logic [N-1:0]   gnt3;
    logic           busy3;
    logic           err3;

    int n_tests = 0;
    int n_fail  = 0;

    dbus_master #(.WIDTH(W), .NSRC(N), .NDST(D), .SETUP_CYC(S)) dut (
        .clk(clk), .rst(rst), .req(req), .src_data(src_data), .src_dst(src_dst),
        .drv_en(drv_en), .bus_oe(bus_oe), .bus_data(bus_data), .ld(ld),
        .gnt(gnt), .busy(busy), .err(err)
    );

    dbus_master #(.WIDTH(W), .NSRC(N), .NDST(D), .SETUP_CYC(S3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .src_data(src_data3), .src_dst(src_dst3),
        .drv_en(drv_en3), .bus_oe(bus_oe3), .bus_data(bus_data3), .ld(ld3),
        .gnt(gnt3), .busy(busy3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transfer-level, SETUP_CYC = S) ----------------
    // ph: 0 = bus idle, 1..S = driving, S+1 = load cycle
    int           ph    = 0;
    int           m_sel = 0;
    int           m_ptr = 0;
    logic [W-1:0] m_dat = '0;
    logic [D-1:0] m_msk = '0;
    bit           found;
    int           k;

    logic [N-1:0] e_drv;
    logic         e_oe;
    logic [W-1:0] e_data;
    logic [D-1:0] e_ld;
    logic [N-1:0] e_gnt;
    logic         e_err;

    // Check every cycle, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        e_oe   = (ph != 0);
        e_drv  = e_oe ? (N'(1) << m_sel) : '0;
        e_data = e_oe ? m_dat : '0;
        e_ld   = (ph == S + 1) ? m_msk : '0;
        e_gnt  = (ph == S + 1) ? (N'(1) << m_sel) : '0;
        e_err  = (ph == S + 1) && (m_msk == '0);

        chk("m_drv_en",   32'(drv_en),   32'(e_drv));
        chk("m_bus_oe",   32'(bus_oe),   32'(e_oe));
        chk("m_bus_data", 32'(bus_data), 32'(e_data));
        chk("m_ld",       32'(ld),       32'(e_ld));
        chk("m_gnt",      32'(gnt),      32'(e_gnt));
        chk("m_busy",     32'(busy),     32'(e_oe));
        chk("m_err",      32'(err),      32'(e_err));
        chk("m_onehot",   32'($onehot0(drv_en)), 32'(1));

        if (rst) begin
            ph    = 0;
            m_ptr = 0;
        end else if (ph == 0) begin
            if (req != '0) begin
                found = 0;
                for (int i = 0; i < N; i++) begin
                    k = (m_ptr + i) % N;
                    if (!found && req[3'(k)]) begin
                        found = 1;
                        m_sel = k;
                    end
                end
                m_dat = src_data[m_sel*W +: W];
                m_msk = src_dst[m_sel*D +: D];
                ph    = 1;
            end
        end else if (ph <= S) begin
            ph = ph + 1;
        end else begin
            ph    = 0;
            m_ptr = (m_sel + 1) % N;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int idx, input logic [W-1:0] d, input logic [D-1:0] m);
        src_data[idx*W +: W] = d;
        src_dst[idx*D +: D]  = m;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        req3 = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [N-1:0] gprev;
    int           got[$];

    initial begin
        rst       = 1'b1;
        req       = '0;
        src_data  = '0;
        src_dst   = '0;
        req3      = '0;
        src_data3 = '0;
        src_dst3  = '0;
        gprev     = '0;
        step();
        step();
        chk("rst_drv_en", 32'(drv_en), 32'(0));
        chk("rst_bus_oe", 32'(bus_oe), 32'(0));
        chk("rst_gnt",    32'(gnt),    32'(0));
        chk("rst_busy",   32'(busy),   32'(0));
        chk("rst_bus_oe3", 32'(bus_oe3), 32'(0));
        rst = 1'b0;

        // Single request from R1
        put(2, 8'd55, 4'b0010);
        req = 6'b000100;
        step();
        chk("single_drv",  32'(drv_en),   32'h04);
        chk("single_data", 32'(bus_data), 32'd55);
        chk("single_busy", 32'(busy),     32'd1);
        step();
        chk("single_ld",  32'(ld),  32'h2);
        chk("single_gnt", 32'(gnt), 32'h04);
        step();
        req = '0;
        chk("single_release", 32'(bus_oe), 32'd0);

        // Simultaneous DR and R0 from reset
        do_reset();
        put(0, 8'd12, 4'b0001);
        put(1, 8'd23, 4'b0100);
        req = 6'b000011;
        step();
        chk("sim_dr_drv",  32'(drv_en),   32'h01);
        chk("sim_dr_data", 32'(bus_data), 32'd12);
        step();
        chk("sim_dr_ld",  32'(ld),  32'h1);
        chk("sim_dr_gnt", 32'(gnt), 32'h01);
        step();
        req = 6'b000010;
        chk("sim_turnaround", 32'(bus_oe), 32'd0);
        step();
        chk("sim_r0_drv",  32'(drv_en),   32'h02);
        chk("sim_r0_data", 32'(bus_data), 32'd23);
        step();
        chk("sim_r0_ld",  32'(ld),  32'h4);
        chk("sim_r0_gnt", 32'(gnt), 32'h02);
        step();
        req = '0;
        chk("sim_release", 32'(bus_oe), 32'd0);

        // Fairness with all six requesting continuously
        do_reset();
        req   = '1;
        gprev = '0;
        for (int c = 0; c < 100 && got.size() < 7; c++) begin
            step();
            req   = ~gprev;
            gprev = gnt;
            chk("fair_onehot", 32'($onehot0(drv_en)), 32'd1);
            if (gnt != '0) got.push_back($clog2(gnt));
        end
        req = '0;
        chk("fair_count", 32'(got.size()), 32'd7);
        for (int i = 0; i < got.size(); i++) begin
            chk("fair_order", 32'(got[i]), 32'(i % N));
        end
        repeat (4) step();

        // Empty destination mask from ALU
        put(5, 8'd4, 4'b0000);
        req = 6'b100000;
        step();
        chk("empty_drv",  32'(drv_en),   32'h20);
        chk("empty_data", 32'(bus_data), 32'd4);
        step();
        chk("empty_gnt", 32'(gnt), 32'h20);
        chk("empty_err", 32'(err), 32'd1);
        chk("empty_ld",  32'(ld),  32'd0);
        step();
        req = '0;
        chk("empty_err_clr", 32'(err), 32'd0);

        // Reset during R3's drive phase
        do_reset();
        put(0, 8'd99, 4'b1000);
        put(4, 8'd77, 4'b0001);
        req = 6'b010000;
        step();
        chk("rmid_drv", 32'(drv_en), 32'h10);
        rst = 1'b1;
        req = 6'b010001;
        step();
        rst = 1'b0;
        chk("rmid_drv0", 32'(drv_en), 32'd0);
        chk("rmid_oe0",  32'(bus_oe), 32'd0);
        chk("rmid_gnt0", 32'(gnt),    32'd0);
        chk("rmid_busy0", 32'(busy),  32'd0);
        step();
        chk("rmid_dr_first", 32'(drv_en), 32'h01);
        chk("rmid_dr_data",  32'(bus_data), 32'd99);
        step();
        chk("rmid_dr_gnt", 32'(gnt), 32'h01);
        step();
        req = 6'b010000;
        step();
        chk("rmid_r3_drv", 32'(drv_en), 32'h10);
        step();
        chk("rmid_r3_gnt", 32'(gnt), 32'h10);
        step();
        req = '0;

        // Random traffic with mid-transfer data churn and occasional resets
        gprev = '0;
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                src_data[i*W +: W] = W'($urandom);
                src_dst[i*D +: D]  = D'($urandom);
            end
            req   = (req & ~gprev) | (N'($urandom & $urandom) & ~gprev);
            gprev = gnt;
            rst   = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        req = '0;
        repeat (6) step();

        // SETUP_CYC = 3 instance: longer drive phase
        src_data3[0 +: W] = 8'd123;
        src_dst3[0 +: D]  = 4'b0001;
        req3 = 6'b000001;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) begin
                src_data3[0 +: W] = 8'd45;
                src_dst3[0 +: D]  = 4'b1000;
            end
            chk("s3_oe",   32'(bus_oe3),   32'd1);
            chk("s3_drv",  32'(drv_en3),   32'h01);
            chk("s3_data", 32'(bus_data3), 32'd123);
            chk("s3_ld",   32'(ld3),       (c == 4) ? 32'h1 : 32'h0);
            chk("s3_gnt",  32'(gnt3),      (c == 4) ? 32'h1 : 32'h0);
        end
        step();
        req3 = '0;
        chk("s3_release", 32'(bus_oe3), 32'd0);
        chk("s3_drv_off", 32'(drv_en3), 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
